// File: rtl/pipeline_mem_ctrl_pkg.sv
// Shared RV32I datapath types: mux-select enums and the memory-controller FSM states.
package rv32i_types;

    typedef enum logic [1:0] {
        PCMUX_PC_PLUS4,
        PCMUX_ALU_OUT,
        PCMUX_ALU_MOD2
    } pcmux_sel_t;

    typedef enum logic {
        ALUMUX1_RS1,
        ALUMUX1_PC
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        ALUMUX2_I_IMM,
        ALUMUX2_U_IMM,
        ALUMUX2_B_IMM,
        ALUMUX2_S_IMM,
        ALUMUX2_J_IMM,
        ALUMUX2_RS2
    } alumux2_sel_t;

    typedef enum logic [1:0] {
        PMC_FETCH,
        PMC_DATA,
        PMC_DONE
    } pmc_state_t;

endpackage

// File: rtl/pipeline_mem_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones until reset.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_mem_ctrl.sv
// Serialises the per-step fetch and data access onto one memory port and pulses load_pipeline.
// Optional performance counters are built when PMC_PERF_CNT_EN is defined.
module pipeline_mem_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iread,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    input  logic        dread,
    input  logic        dwrite,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        load_pipeline,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_byte_enable,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
`ifdef PMC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] wait_cycles
`endif
);

    pmc_state_t state, state_next;
    logic       fetch_active;
    logic       data_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PMC_FETCH;
            inst      <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_next;
            if (fetch_active && pmem_resp)
                inst <= pmem_rdata;
            if (data_active && dread && !dwrite && pmem_resp)
                mem_rdata <= pmem_rdata;
        end
    end

    // Strobes depend on the state register and the held request inputs only,
    // and are forced low while reset is asserted.
    always_comb begin
        fetch_active     = rst_n && (state == PMC_FETCH) && iread;
        data_active      = rst_n && (state == PMC_DATA);
        pmem_read        = fetch_active || (data_active && dread && !dwrite);
        pmem_write       = data_active && dwrite;
        pmem_address     = '0;
        pmem_wdata       = '0;
        pmem_byte_enable = '0;
        load_pipeline    = (state == PMC_DONE);
        state_next       = state;

        if (fetch_active)
            pmem_address = inst_addr;
        else if (data_active)
            pmem_address = mem_address;
        if (pmem_write) begin
            pmem_wdata       = mem_wdata;
            pmem_byte_enable = mem_byte_enable;
        end

        case (state)
            PMC_FETCH: begin
                if (!iread || pmem_resp)
                    state_next = (dread || dwrite) ? PMC_DATA : PMC_DONE;
            end
            PMC_DATA: begin
                if (pmem_resp || !(dread || dwrite))
                    state_next = PMC_DONE;
            end
            PMC_DONE: state_next = PMC_FETCH;
            default:  state_next = PMC_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && (state == PMC_DATA))
            assert (!(dread && dwrite));
    end

`ifdef PMC_PERF_CNT_EN
    logic wait_inc;

    always_comb begin
        wait_inc = (pmem_read || pmem_write) && !pmem_resp;
    end

    sat_counter #(.CNT_W(CNT_W)) u_step_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_pipeline),
        .count (step_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .count (wait_cycles)
    );
`endif

endmodule
